// File: rtl/reconf_fir_pkg.sv
// Shared definitions for the FIR microcode loader: FSM states, CRC-16 constants
// and the command-word field offsets shared with the FIR microcode format.
package reconf_fir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HOLD    = 3'd1,
      ST_LOAD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_ERR     = 3'd4
   } state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // One SLICE_CFG_W field per FIR stage, stage 0 in the low bits.
   localparam int SLICE_CFG_W    = 8;
   localparam int CMD_STAGE0_OFF = 0;
   localparam int CMD_STAGE1_OFF = CMD_STAGE0_OFF + SLICE_CFG_W;
   localparam int CMD_STAGE2_OFF = CMD_STAGE1_OFF + SLICE_CFG_W;
   localparam int CMD_STAGE3_OFF = CMD_STAGE2_OFF + SLICE_CFG_W;

endpackage

// File: rtl/reconf_fir_ucode_loader_crc.sv
// Single-cycle CRC-16-CCITT update over one WIDTH-bit word, MSB first.
module crc16_ccitt_word
   import reconf_fir_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [15:0]      crc_in,
   input  logic [WIDTH-1:0] data,
   output logic [15:0]      crc_out
);

   logic [15:0] c;
   logic        fb;

   always_comb begin
      c  = crc_in;
      fb = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         fb = c[15] ^ data[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ CRC16_POLY;
      end
      crc_out = c;
   end

endmodule

// File: rtl/reconf_fir_ucode_loader.sv
// Holds the FIR in reset, streams DEEP microcode words into its sequencer and
// releases it on a correctly sized load. Optional checksum: UCODE_LOADER_CRC_EN.
//
// state   | meaning
// IDLE    | waiting for start; fir_rst low only after a good load
// HOLD    | fir_rst asserted for RST_HOLD cycles
// LOAD    | accepting words, forwarding each to cfg_data one cycle later
// RELEASE | last word on cfg_data; fir_rst drops and done pulses next cycle
// ERR     | wrong word count, err_len set, waits for start
module reconf_fir_ucode_loader
   import reconf_fir_pkg::*;
#(
   parameter int CFG_WIDTH          = 32,
   parameter int SEQUENCER_DEEPBITS = 5,
   parameter int RST_HOLD           = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic                 s_last,
   input  logic [CFG_WIDTH-1:0] s_data,
   output logic                 cfg_valid,
   output logic [CFG_WIDTH-1:0] cfg_data,
   output logic                 fir_rst,
   output logic                 busy,
   output logic                 done,
   output logic                 err_len,
   output logic [15:0]          crc
);

   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
   localparam logic [SEQUENCER_DEEPBITS-1:0] LAST_IDX = '1;
   localparam logic [SEQUENCER_DEEPBITS-1:0] CNT_ONE  = SEQUENCER_DEEPBITS'(1);

   state_t                        state, state_nxt;
   logic [HW-1:0]                 hold_cnt;
   logic [SEQUENCER_DEEPBITS-1:0] word_cnt;
   logic                          accept;
   logic                          at_last;
   logic                          start_ok;

   assign accept   = s_valid && s_ready;
   assign at_last  = (word_cnt == LAST_IDX);
   assign start_ok = start && ((state == ST_IDLE) || (state == ST_ERR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_HOLD;
         ST_HOLD:    if (hold_cnt == '0) state_nxt = ST_LOAD;
         ST_LOAD: begin
            // s_last must coincide exactly with the final counter value
            if (accept) begin
               if (s_last)       state_nxt = at_last ? ST_RELEASE : ST_ERR;
               else if (at_last) state_nxt = ST_ERR;
            end
         end
         ST_RELEASE: state_nxt = ST_IDLE;
         ST_ERR:     if (start) state_nxt = ST_HOLD;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = (state == ST_LOAD);
      busy    = (state == ST_HOLD) || (state == ST_LOAD) || (state == ST_RELEASE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         word_cnt  <= '0;
         cfg_valid <= 1'b0;
         cfg_data  <= '0;
         fir_rst   <= 1'b1;
         done      <= 1'b0;
         err_len   <= 1'b0;
      end else begin
         cfg_valid <= accept;
         if (accept) cfg_data <= s_data;
         done <= (state == ST_RELEASE);

         if (start_ok)                                hold_cnt <= HOLD_LOAD;
         else if ((state == ST_HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - HOLD_ONE;

         if (state == ST_HOLD)       word_cnt <= '0;
         else if (accept && !at_last) word_cnt <= word_cnt + CNT_ONE;

         if (start_ok)                 fir_rst <= 1'b1;
         else if (state == ST_RELEASE) fir_rst <= 1'b0;

         if ((state == ST_LOAD) && accept && (s_last ^ at_last)) err_len <= 1'b1;
         else if ((state == ST_ERR) && start)                     err_len <= 1'b0;
      end
   end

`ifdef UCODE_LOADER_CRC_EN
   logic [15:0] crc_q;
   logic [15:0] crc_step;

   crc16_ccitt_word #(.WIDTH(CFG_WIDTH)) u_crc (
      .crc_in  (crc_q),
      .data    (s_data),
      .crc_out (crc_step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        crc_q <= '0;
      else if (start_ok) crc_q <= CRC16_INIT;
      else if (accept)   crc_q <= crc_step;
   end

   assign crc = crc_q;
`else
   assign crc = '0;
`endif

endmodule

// File: tb/tb_reconf_fir_ucode_loader.sv
// Scoreboard bench for the microcode loader: random loads against a queue-based model.
module tb_reconf_fir_ucode_loader;

   localparam int RST_HOLD = 4;
   localparam int DEEP     = 32;

   logic        clk = 1'b0;
   logic        rst_n, start, s_valid, s_ready, s_last;
   logic [31:0] s_data, cfg_data;
   logic        cfg_valid, fir_rst, busy, done, err_len;
   logic [15:0] crc;

   reconf_fir_ucode_loader #(.CFG_WIDTH(32), .SEQUENCER_DEEPBITS(5), .RST_HOLD(RST_HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_last(s_last), .s_data(s_data), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .fir_rst(fir_rst), .busy(busy), .done(done), .err_len(err_len), .crc(crc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_words[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          strobes = 0;

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         vectors++;
         if (cfg_valid) strobes++;
         if (cfg_valid !== 1'b1 || cfg_data !== e.d) begin
            miscompares++;
            $display("FAIL cfg_word cycle %0d: got valid=%0b data=%h, expected valid=1 data=%h",
                     cyc, cfg_valid, cfg_data, e.d);
         end
      end else if (cfg_valid !== 1'b0) begin
         vectors++;
         miscompares++;
         strobes++;
         $display("FAIL cfg_spurious cycle %0d: got valid=%0b data=%h, expected valid=0",
                  cyc, cfg_valid, cfg_data);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Byte-wise CRC-16-CCITT over the words of the last load, high byte first.
   function automatic logic [15:0] crc_ref();
      logic [15:0] c = 16'hFFFF;
      logic [7:0]  b;
      foreach (model_words[i]) begin
         for (int k = 3; k >= 0; k--) begin
            b = model_words[i][8*k +: 8];
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
         end
      end
      return c;
   endfunction

   function automatic logic [15:0] crc_exp();
`ifdef UCODE_LOADER_CRC_EN
      return crc_ref();
`else
      return 16'h0000;
`endif
   endfunction

   // vmode: 0 full rate, 1 toggle 1010.., 2 random. dmode: 0 index, 1 random, 2 zero.
   // last_idx: word carrying s_last (<0 = none). abort_at: pulse rst_n after this many words.
   task automatic run_load(input int vmode, input int dmode, input int last_idx,
                           input bit sv_start, input int abort_at);
      int          idx = 0;
      int          tog = 0;
      int          guard = 0;
      int          s0;
      bit          fin = 0;
      bit          v;
      logic [31:0] w;
      @(negedge clk);
      start   = 1'b1;
      s_valid = sv_start;
      s_data  = 32'hDEAD_BEEF;
      s_last  = sv_start;
      @(negedge clk);
      start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      check("start_err_clr", 32'(err_len), 32'd0);
      check("start_busy", 32'(busy), 32'd1);
      model_words.delete();
      s0 = strobes;
      for (int k = 0; k < RST_HOLD; k++) begin
         check("hold_fir_rst", 32'(fir_rst), 32'd1);
         check("hold_ready", 32'(s_ready), 32'd0);
         @(negedge clk);
      end
      while (!fin) begin
         check("load_ready", 32'(s_ready), 32'd1);
         check("load_fir_rst", 32'(fir_rst), 32'd1);
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((tog % 2) == 0) : 1'($urandom_range(0, 1));
         tog++;
         w = (dmode == 0) ? 32'(idx) : (dmode == 1) ? $urandom : 32'h0;
         s_valid = v; s_data = w; s_last = (idx == last_idx);
         if (v) begin
            exp_q.push_back('{d: w, due: cyc + 1});
            model_words.push_back(w);
            if (idx == last_idx || idx == DEEP - 1) fin = 1;
            idx++;
            if (idx == abort_at) fin = 1;
         end
         @(negedge clk);
         guard++;
         if (guard > 1000) begin
            check("load_timeout", 32'(guard), 32'd0);
            fin = 1;
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      check("strobe_count", 32'(strobes - s0), 32'(idx));
      if (abort_at > 0) begin
         rst_n = 1'b0;
         #1;
         check("abort_fir_rst", 32'(fir_rst), 32'd1);
         check("abort_ready", 32'(s_ready), 32'd0);
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_crc", 32'(crc), 32'd0);
         s_valid = 1'b1; s_data = 32'h5555_AAAA;
         repeat (2) @(negedge clk);
         rst_n = 1'b1; s_valid = 1'b0;
         @(negedge clk);
         check("post_abort_ready", 32'(s_ready), 32'd0);
         check("post_abort_fir_rst", 32'(fir_rst), 32'd1);
      end else if (last_idx == DEEP - 1) begin
         check("release_busy", 32'(busy), 32'd1);
         check("release_fir_rst", 32'(fir_rst), 32'd1);
         check("release_done", 32'(done), 32'd0);
         @(negedge clk);
         check("done_pulse", 32'(done), 32'd1);
         check("done_fir_rst", 32'(fir_rst), 32'd0);
         check("done_busy", 32'(busy), 32'd0);
         check("done_err", 32'(err_len), 32'd0);
         check("done_crc", 32'(crc), 32'(crc_exp()));
         @(negedge clk);
         check("done_one_cycle", 32'(done), 32'd0);
         check("crc_stable", 32'(crc), 32'(crc_exp()));
      end else begin
         for (int k = 0; k < 3; k++) begin
            check("err_flag", 32'(err_len), 32'd1);
            check("err_fir_rst", 32'(fir_rst), 32'd1);
            check("err_ready", 32'(s_ready), 32'd0);
            check("err_busy", 32'(busy), 32'd0);
            check("err_done", 32'(done), 32'd0);
            s_valid = 1'b1; s_data = $urandom; s_last = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         s_valid = 1'b0; s_last = 1'b0;
      end
   endtask

   initial begin
      int kind;
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
      #12;
      check("rst_fir_rst", 32'(fir_rst), 32'd1);
      check("rst_cfg_valid", 32'(cfg_valid), 32'd0);
      check("rst_cfg_data", cfg_data, 32'd0);
      check("rst_ready", 32'(s_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err_len), 32'd0);
      check("rst_crc", 32'(crc), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_load(0, 0, DEEP - 1, 1'b1, -1);   // full rate, start with s_valid in IDLE
      run_load(1, 0, DEEP - 1, 1'b0, -1);   // toggled valid
      run_load(2, 1, DEEP - 1, 1'b0, -1);   // random valid and data
      run_load(0, 0, 10, 1'b0, -1);         // short load
      run_load(0, 1, -1, 1'b0, -1);         // long load from ERR
      run_load(0, 0, DEEP - 1, 1'b0, 16);   // reset after word 15
      run_load(0, 2, DEEP - 1, 1'b0, -1);   // all zero words
`ifdef UCODE_LOADER_CRC_EN
      check("crc_zero_load", 32'(crc), 32'(crc_ref()));
`else
      check("crc_disabled", 32'(crc), 32'd0);
`endif
      for (int n = 0; n < 5; n++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0)      run_load(2, 1, DEEP - 1, 1'b0, -1);
         else if (kind == 1) run_load(2, 1, $urandom_range(0, DEEP - 2), 1'b0, -1);
         else                run_load(2, 1, -1, 1'b0, -1);
      end
      run_load(0, 1, DEEP - 1, 1'b0, -1);
      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reconf_fir_ucode_loader.md
RECONF_FIR_UCODE_LOADER -- requirements
Module: reconf_fir_ucode_loader

Interface
REQ-001 SHALL have parameter CFG_WIDTH, default 32, giving the width of the microcode word and of cfg_data (one SLICE_CFG_W field per FIR stage).
REQ-002 SHALL have parameter SEQUENCER_DEEPBITS, default 5, giving the words per load as DEEP = 2**SEQUENCER_DEEPBITS.
REQ-003 SHALL have parameter RST_HOLD, default 4, giving the number of cycles fir_rst is held before loading.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  single-cycle request to begin a load.
REQ-007 s_valid / s_ready / s_last  in / out / in  1 each  microcode word stream handshake; s_last marks the final word.
REQ-008 s_data  in  CFG_WIDTH  microcode word.
REQ-009 cfg_valid  out  1  sequencer write strobe to the FIR.
REQ-010 cfg_data  out  CFG_WIDTH  sequencer write data to the FIR.
REQ-011 fir_rst  out  1  active-high reset driven to the FIR.
REQ-012 busy  out  1  high in any state other than IDLE and ERR.
REQ-013 done  out  1  one-cycle pulse on a successful load.
REQ-014 err_len  out  1  sticky length-error flag.
REQ-015 crc  out  16  checksum of the last load (see Configuration).

Function
REQ-016 FSM states SHALL be IDLE, HOLD, LOAD, RELEASE and ERR.
REQ-017 IDLE + start SHALL go to HOLD; ERR + start SHALL clear err_len and go to HOLD; start in any other state SHALL be ignored.
REQ-018 HOLD SHALL assert fir_rst and count exactly RST_HOLD cycles, then go to LOAD with the word counter at 0.
REQ-019 s_ready SHALL be 1 only in LOAD; a word is accepted when s_valid && s_ready.
REQ-020 Each accepted word SHALL appear on cfg_data with cfg_valid=1 exactly one cycle after acceptance.
- cfg_valid is 0 in all other cycles.
- cfg_data holds its last value when cfg_valid=0.
REQ-021 Words SHALL be forwarded in arrival order; one word per cycle at full rate, with no bubbles while s_valid stays high.
REQ-022 The word counter SHALL increment on each accepted word and count 0..DEEP-1.
REQ-023 s_last accepted with counter == DEEP-1 SHALL go to RELEASE.
REQ-024 s_last accepted with counter < DEEP-1 SHALL go to ERR (short load).
REQ-025 A word accepted with counter == DEEP-1 and s_last=0 SHALL go to ERR (long load); the counter SHALL NOT wrap.
REQ-026 The offending word in REQ-024/REQ-025 SHALL still be forwarded on cfg_data.
REQ-027 RELEASE SHALL last one cycle, after the last cfg_valid. Next cycle:
- fir_rst = 0;
- done = 1 for one cycle;
- state = IDLE.
REQ-028 fir_rst SHALL be 1 in HOLD, LOAD, RELEASE and ERR, and 0 in IDLE only after a successful load.
REQ-029 ERR SHALL set err_len, keep fir_rst=1 and s_ready=0, and hold until start.
REQ-030 start and s_valid in the same IDLE cycle: the word SHALL NOT be accepted.

Reset
REQ-031 When rst_n=0, the block SHALL asynchronously force:
- state = IDLE;
- fir_rst = 1 (FIR held in reset until the first good load);
- cfg_valid, s_ready, busy, done, err_len = 0;
- counters = 0;
- cfg_data = 0;
- crc = 0.
REQ-032 Reset mid-LOAD SHALL abort the load with no further cfg_valid; a new start SHALL be required.

Configuration
REQ-033 With macro UCODE_LOADER_CRC_EN defined:
- crc is CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR) over all CFG_WIDTH bits of every accepted word;
- it reinitialises on entering HOLD and is stable from the done pulse until the next start.
REQ-034 Without UCODE_LOADER_CRC_EN, crc SHALL be constant 0 and the CRC logic SHALL be absent.

Structure
REQ-035 A shared package reconf_fir_pkg SHALL hold:
- the FSM state enum;
- the CRC-16 polynomial and init constants;
- the CMD_* field offsets shared with the FIR microcode format.
REQ-036 One sub-module, crc16_ccitt_word (parallel CFG_WIDTH-bit CRC step), SHALL be instantiated only under UCODE_LOADER_CRC_EN.

Verification
REQ-037 Reset then start, RST_HOLD=4, 32 words 0x0..0x1F at full rate with s_last on 0x1F -> fir_rst=1 for 4+32+1 cycles; cfg_data 0x0..0x1F, one cycle after each accept; done pulse; fir_rst=0.
REQ-038 s_valid toggled 1010... over a 32-word load -> cfg_valid follows with 1-cycle latency; exactly 32 strobes; done.
REQ-039 s_last on word index 10 -> 11 cfg_valid; err_len=1; fir_rst stays 1; s_ready=0. Then start -> err_len=0; HOLD entered.
REQ-040 32 words with no s_last -> err_len=1 after word 31; s_ready=0 afterwards; no 33rd cfg_valid.
REQ-041 rst_n pulsed low after word 15 -> immediate IDLE; fir_rst=1; no further cfg_valid; start restarts cleanly.
REQ-042 With UCODE_LOADER_CRC_EN, load 32 words of 0x00000000 -> crc equals the reference-model CRC-16-CCITT of 128 zero bytes; without the macro, crc=0.
